// File: rtl/spk_out_pack_pkg.sv
// Shared definitions for the spike output packer: flit type codes, flit field
// offsets and the destination-table entry layout.
package spk_out_pack_pkg;

    localparam int unsigned FW        = 59;
    localparam int unsigned FTW       = 3;
    localparam int unsigned NNW       = 12;
    localparam int unsigned DST_WIDTH = 21;
    localparam int unsigned DST_DEPTH = 4;
    localparam int unsigned DST_AW    = $clog2(DST_DEPTH);
    localparam int unsigned FIFO_AW   = 4;

    // Flit type codes carried in the top FTW bits of every flit
    localparam logic [FTW-1:0] CFG_TYPE  = 3'b001;
    localparam logic [FTW-1:0] SPK_TYPE  = 3'b010;
    localparam logic [FTW-1:0] TICK_TYPE = 3'b011;

    // Flit field offsets (LSB of each field), packed from the MSB downwards
    localparam int unsigned FLIT_TYPE_LSB = FW - FTW;
    localparam int unsigned FLIT_DST_LSB  = FLIT_TYPE_LSB - DST_WIDTH;
    localparam int unsigned FLIT_NIDX_LSB = FLIT_DST_LSB - NNW;

    // Destination entry layout: {x, y, r2, r1, flg}, flg in bit 0
    localparam int unsigned DST_FLG_BIT = 0;
    localparam int unsigned DST_R1_LSB  = 1;
    localparam int unsigned DST_R1_W    = 5;
    localparam int unsigned DST_R2_LSB  = DST_R1_LSB + DST_R1_W;
    localparam int unsigned DST_R2_W    = 5;
    localparam int unsigned DST_Y_LSB   = DST_R2_LSB + DST_R2_W;
    localparam int unsigned DST_Y_W     = 5;
    localparam int unsigned DST_X_LSB   = DST_Y_LSB + DST_Y_W;
    localparam int unsigned DST_X_W     = 5;

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } pack_state_e;

    function automatic logic [FW-1:0] make_spike_flit(input logic [DST_WIDTH-1:0] dst,
                                                      input logic [NNW-1:0]       nidx);
        logic [FW-1:0] flit;
        flit                             = '0;
        flit[FLIT_TYPE_LSB +: FTW]       = SPK_TYPE;
        flit[FLIT_DST_LSB +: DST_WIDTH]  = dst;
        flit[FLIT_NIDX_LSB +: NNW]       = nidx;
        return flit;
    endfunction

endpackage

// File: rtl/spk_out_pack_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and occupancy count.
module spk_out_pack_sync_fifo #(
    parameter int unsigned Width = 12,
    parameter int unsigned AddrW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AddrW:0]   count
);

    localparam int unsigned   Depth    = 1 << AddrW;
    localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q;
    logic [AddrW-1:0] rd_ptr_q;
    logic [AddrW:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == DepthCnt);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally at 2^AddrW
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spk_out_pack.sv
// Spike output packer: queues fired neuron indices and fans each one out as a
// spike flit to every valid destination-table entry, then reports timestep drain.
module spk_out_pack
    import spk_out_pack_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spk_in_vld,
    input  logic [NNW-1:0]       spk_in_nidx,
    output logic                 spk_in_rdy,
    input  logic                 tick_in,
    input  logic                 cfg_dst_we,
    input  logic [DST_AW-1:0]    cfg_dst_waddr,
    input  logic [DST_WIDTH-1:0] cfg_dst_wdata,
    output logic                 flit_out_vld,
    output logic [FW-1:0]        flit_out_data,
    input  logic                 flit_out_rdy,
    output logic                 step_done,
    output logic                 fifo_ovf
);

    logic [NNW-1:0]       fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FIFO_AW:0]     fifo_count;
    logic                 fifo_pop;

    logic [DST_WIDTH-1:0] dst_tbl_q [DST_DEPTH];
    logic [DST_DEPTH-1:0] dst_vld;

    pack_state_e          state_q;
    logic [DST_AW-1:0]    ptr_q;
    logic [NNW-1:0]       nidx_q;
    logic                 flit_vld_q;
    logic [FW-1:0]        flit_data_q;

    logic                 first_found;
    logic [DST_AW-1:0]    first_idx;
    logic                 next_found;
    logic [DST_AW-1:0]    next_idx;

    logic                 tick_pending_q;
    logic                 fifo_ovf_q;
    logic                 push_acc;

    spk_out_pack_sync_fifo #(
        .Width (NNW),
        .AddrW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (spk_in_vld),
        .wdata (spk_in_nidx),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign spk_in_rdy = !fifo_full;
    assign push_acc   = spk_in_vld && !fifo_full;
    assign fifo_pop   = (state_q == StIdle) && !fifo_empty;

    // Destination table; entries are cleared so flg=0 after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DST_DEPTH; i++) begin
                dst_tbl_q[i] <= '0;
            end
        end else if (cfg_dst_we) begin
            dst_tbl_q[cfg_dst_waddr] <= cfg_dst_wdata;
        end
    end

    always_comb begin
        for (int i = 0; i < DST_DEPTH; i++) begin
            dst_vld[i] = dst_tbl_q[i][DST_FLG_BIT];
        end
    end

    // Lowest valid entry overall, and lowest valid entry above the current pointer
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int unsigned i = 0; i < DST_DEPTH; i++) begin
            if (dst_vld[i] && !first_found) begin
                first_found = 1'b1;
                first_idx   = DST_AW'(i);
            end
            if (dst_vld[i] && !next_found && (i > 32'(ptr_q))) begin
                next_found = 1'b1;
                next_idx   = DST_AW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            nidx_q      <= '0;
            flit_vld_q  <= 1'b0;
            flit_data_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // A spike with no valid destination is popped and discarded
                    if (!fifo_empty) begin
                        nidx_q <= fifo_rdata;
                        if (first_found) begin
                            ptr_q       <= first_idx;
                            flit_vld_q  <= 1'b1;
                            flit_data_q <= make_spike_flit(dst_tbl_q[first_idx], fifo_rdata);
                            state_q     <= StSend;
                        end
                    end
                end
                StSend: begin
                    if (flit_out_rdy) begin
                        if (next_found) begin
                            ptr_q       <= next_idx;
                            flit_data_q <= make_spike_flit(dst_tbl_q[next_idx], nidx_q);
                        end else begin
                            flit_vld_q <= 1'b0;
                            state_q    <= StIdle;
                        end
                    end
                end
                default: begin
                    flit_vld_q <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    assign flit_out_vld  = flit_vld_q;
    assign flit_out_data = flit_data_q;

    // Drained: nothing queued, nothing in flight, nothing arriving this cycle
    assign step_done = tick_pending_q && (fifo_count == '0) && (state_q == StIdle) && !push_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_pending_q <= 1'b0;
        end else if (step_done) begin
            tick_pending_q <= 1'b0;
        end else if (tick_in) begin
            tick_pending_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_ovf_q <= 1'b0;
        end else if (spk_in_vld && fifo_full) begin
            fifo_ovf_q <= 1'b1;
        end
    end

    assign fifo_ovf = fifo_ovf_q;

endmodule
